// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op and state encodings plus op-class helpers for the iterative mul/div unit
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_word(input muldiv_op_e op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_mul(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    endfunction

    function automatic logic is_mulh(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    // rs1 treated as signed. MUL/MULW only keep the low half, which is
    // identical for signed and unsigned operands, so they run unsigned.
    function automatic logic is_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    // rs2 treated as signed (MULHSU differs from rs1 here).
    function automatic logic rs2_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiplier, restoring divider and iteration counter
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   load             capture operand magnitudes and start a new op
//   load_mul         op being loaded is a multiply
//   load_word        op being loaded works on 32-bit operands
//   a_mag, b_mag     unsigned operand magnitudes
//   step_mul         retire MUL_BITS multiplier bits this cycle
//   step_div         retire one quotient bit this cycle
//   last_iter        the step taken this cycle is the final one
//   prod             2*XLEN-bit unsigned product of magnitudes
//   quo, rem         unsigned quotient and remainder of magnitudes
module muldiv_datapath #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_mul,
    input  logic              load_word,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    input  logic              step_mul,
    input  logic              step_div,
    output logic              last_iter,
    output logic [2*XLEN-1:0] prod,
    output logic [XLEN-1:0]   quo,
    output logic [XLEN-1:0]   rem
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] ITER_MUL   = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0] ITER_MUL_W = CW'(32 / MUL_BITS);
    localparam logic [CW-1:0] ITER_DIV   = CW'(XLEN);
    localparam logic [CW-1:0] ITER_DIV_W = CW'(32);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   dvsr;
    logic [CW-1:0]     cnt;

    logic [2*XLEN-1:0] mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ge;

    // Multiplicand moves left instead of the product moving right, so the
    // product lands at bit 0 whatever the operand width.
    always_comb begin
        mul_sum = acc;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) begin
                mul_sum = mul_sum + (mcand << i);
            end
        end
    end

    always_comb begin
        div_sh   = {rem_r, quo_r[XLEN-1]};
        div_diff = div_sh - {1'b0, dvsr};
        div_ge   = (div_sh >= {1'b0, dvsr});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            dvsr   <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
            rem_r  <= '0;
            // Word dividends start at the top so 32 shifts consume them exactly.
            quo_r  <= load_word ? (a_mag << 32) : a_mag;
            dvsr   <= b_mag;
            if (load_mul) begin
                cnt <= load_word ? ITER_MUL_W : ITER_MUL;
            end else begin
                cnt <= load_word ? ITER_DIV_W : ITER_DIV;
            end
        end else if (step_mul) begin
            acc    <= mul_sum;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt - 1'b1;
        end else if (step_div) begin
            rem_r  <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            quo_r  <= {quo_r[XLEN-2:0], div_ge};
            cnt    <= cnt - 1'b1;
        end
    end

    assign last_iter = (cnt == CW'(1));
    assign prod      = acc;
    assign quo       = quo_r;
    assign rem       = rem_r;

endmodule

// File: rtl/exec_muldiv_iter.sv
// rtl/exec_muldiv_iter.sv - iterative RV64M multiply/divide unit with EX stall and MEM handshake
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid, in_ready    op request from EX / unit idle and able to accept
//   op                    muldiv_op_e encoding
//   rs1_val, rs2_val      forwarded operands
//   rd_in, rd_out         destination tag in / tag of the held result
//   flush                 abandon whatever is in flight
//   out_valid, out_ready  result handshake towards MEM
//   result                final value, W ops sign-extended from bit 31
//   ex_stall              unit busy (any state but idle)
module exec_muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [5:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [5:0]      rd_out,
    output logic            ex_stall
);

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_e     state, state_n;
    muldiv_op_e op_in, op_q;
    logic       word_q, neg_q;
    logic [5:0] rd_q;

    logic            word_in, s1_in, s2_in, a_neg, b_neg, neg_in;
    logic            div0, ovf, special, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_val, spec_res;

    logic              last_iter;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fix_val, fix_res;

    assign op_in  = muldiv_op_e'(op);
    assign accept = (state == ST_IDLE) && in_valid && !flush;

    // Operand preparation at accept: N-bit extension, sign capture, magnitude.
    always_comb begin
        word_in = (XLEN == 64) && is_word(op_in);
        s1_in   = is_signed(op_in);
        s2_in   = rs2_signed(op_in);
        a_ext   = rs1_val;
        b_ext   = rs2_val;
        if (word_in) begin
            a_ext = s1_in ? sext_w(rs1_val[31:0]) : XLEN'(rs1_val[31:0]);
            b_ext = s2_in ? sext_w(rs2_val[31:0]) : XLEN'(rs2_val[31:0]);
        end
        a_neg   = s1_in && a_ext[XLEN-1];
        b_neg   = s2_in && b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        // Remainder follows the dividend sign; everything else the sign product.
        neg_in  = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);

        min_val = word_in ? sext_w(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div0    = !is_mul(op_in) && (b_ext == '0);
        ovf     = !is_mul(op_in) && s1_in && (a_ext == min_val) && (b_ext == '1);
        special = div0 || ovf;
        if (div0) begin
            spec_val = is_rem(op_in) ? a_ext : '1;
        end else begin
            spec_val = is_rem(op_in) ? '0 : a_ext;
        end
        spec_res = word_in ? sext_w(spec_val[31:0]) : spec_val;
    end

    muldiv_datapath #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_mul  (is_mul(op_in)),
        .load_word (word_in),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .step_mul  (state == ST_MUL),
        .step_div  (state == ST_DIV),
        .last_iter (last_iter),
        .prod      (prod),
        .quo       (quo),
        .rem       (rem)
    );

    // Sign fix-up of the magnitude results.
    always_comb begin
        prod_s = neg_q ? -prod : prod;
        if (is_mul(op_q)) begin
            fix_val = is_mulh(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end else if (is_rem(op_q)) begin
            fix_val = neg_q ? -rem : rem;
        end else begin
            fix_val = neg_q ? -quo : quo;
        end
        fix_res = word_q ? sext_w(fix_val[31:0]) : fix_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = is_mul(op_in) ? ST_MUL : ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_iter) begin
                    state_n = ST_FIX;
                end
            end
            ST_FIX:  state_n = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Flush overrides everything, including a completing handshake.
        if (flush) begin
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_MUL;
            word_q <= 1'b0;
            neg_q  <= 1'b0;
            rd_q   <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_in;
                word_q <= word_in;
                neg_q  <= neg_in;
                rd_q   <= rd_in;
                if (special) begin
                    result <= spec_res;
                    rd_out <= rd_in;
                end
            end
            if ((state == ST_FIX) && !flush) begin
                result <= fix_res;
                rd_out <= rd_q;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign ex_stall  = (state != ST_IDLE);

endmodule

// File: tb/tb_exec_muldiv_iter.sv
// tb/tb_exec_muldiv_iter.sv - randomized and directed bench for exec_muldiv_iter
module tb_exec_muldiv_iter;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] rs1_val = '0;
    logic [63:0] rs2_val = '0;
    logic [5:0]  rd_in = '0;

    logic        in_ready1, out_valid1, ex_stall1;
    logic [63:0] result1;
    logic [5:0]  rd_out1;
    logic        in_ready4, out_valid4, ex_stall4;
    logic [63:0] result4;
    logic [5:0]  rd_out4;

    exec_muldiv_iter #(.XLEN(64), .MUL_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .rd_out(rd_out1), .ex_stall(ex_stall1)
    );

    exec_muldiv_iter #(.XLEN(64), .MUL_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
        .result(result4), .rd_out(rd_out4), .ex_stall(ex_stall4)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_mul_op(input logic [3:0] o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    endfunction

    function automatic logic is_rem_op(input logic [3:0] o);
        return o inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_sdiv_op(input logic [3:0] o);
        return o inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    // Architectural RV64M result from plain wide arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, p;
        logic [31:0]  r32, ua32, ub32;
        logic [63:0]  r64;
        int           x32, y32;
        longint       x64, y64;
        if (is_mul_op(o)) begin
            sa = (o == OP_MULH || o == OP_MULHSU) ? {{64{a[63]}}, a} : {64'b0, a};
            sb = (o == OP_MULH) ? {{64{b[63]}}, b} : {64'b0, b};
            p  = sa * sb;
            if (o == OP_MUL)  return p[63:0];
            if (o == OP_MULW) return {{32{p[31]}}, p[31:0]};
            return p[127:64];
        end
        if (o >= OP_MULW) begin
            ua32 = a[31:0];
            ub32 = b[31:0];
            x32  = a[31:0];
            y32  = b[31:0];
            if (ub32 == 0)
                r32 = is_rem_op(o) ? ua32 : 32'hFFFF_FFFF;
            else if (is_sdiv_op(o) && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF)
                r32 = is_rem_op(o) ? 32'd0 : ua32;
            else if (is_sdiv_op(o))
                r32 = is_rem_op(o) ? x32 % y32 : x32 / y32;
            else
                r32 = is_rem_op(o) ? ua32 % ub32 : ua32 / ub32;
            return {{32{r32[31]}}, r32};
        end
        x64 = a;
        y64 = b;
        if (b == 0)
            r64 = is_rem_op(o) ? a : '1;
        else if (is_sdiv_op(o) && a == 64'h8000_0000_0000_0000 && b == '1)
            r64 = is_rem_op(o) ? 64'd0 : a;
        else if (is_sdiv_op(o))
            r64 = is_rem_op(o) ? x64 % y64 : x64 / y64;
        else
            r64 = is_rem_op(o) ? a % b : a / b;
        return r64;
    endfunction

    // Edges from the accepting edge (inclusive) until out_valid is seen.
    function automatic int exp_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input int mb);
        logic word;
        logic div0, ovf;
        int   n;
        word = (o >= OP_MULW);
        n    = word ? 32 : 64;
        if (is_mul_op(o)) return n / mb + 2;
        div0 = word ? (b[31:0] == 0) : (b == 0);
        ovf  = is_sdiv_op(o) && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                      : (a == 64'h8000_0000_0000_0000 && b == '1));
        return (div0 || ovf) ? 1 : n + 2;
    endfunction

    // Issue one op to both units, wait for both, optionally hold MEM off, then drain.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [5:0] rd, input int hold);
        int          cnt, l1, l4;
        logic        stall_ok;
        logic [63:0] exp;
        exp      = ref_result(o, a, b);
        op       = o;
        rs1_val  = a;
        rs2_val  = b;
        rd_in    = rd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1; l1 = 0; l4 = 0; stall_ok = 1'b1;
        while ((l1 == 0 || l4 == 0) && cnt < 300) begin
            if (l1 == 0 && out_valid1) l1 = cnt;
            if (l4 == 0 && out_valid4) l4 = cnt;
            if (!ex_stall1 || !ex_stall4) stall_ok = 1'b0;
            if (l1 == 0 || l4 == 0) begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        check({tag, " lat1"}, l1, exp_lat(o, a, b, 1));
        check({tag, " lat4"}, l4, exp_lat(o, a, b, 4));
        check({tag, " res1"}, result1, exp);
        check({tag, " res4"}, result4, exp);
        check({tag, " rd"}, {rd_out1, rd_out4}, {rd, rd});
        check({tag, " stall"}, stall_ok, 1'b1);
        for (int i = 0; i < hold; i++) begin
            // A competing request must be ignored while the result is held.
            in_valid = 1'b1;
            op       = OP_DIVU;
            rs2_val  = '0;
            rd_in    = ~rd;
            @(posedge clk); #1;
            check({tag, " hold"}, {result1, rd_out1, in_ready1, out_valid1, ex_stall1, result4, rd_out4},
                  {exp, rd, 3'b011, exp, rd});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " drain"}, {in_ready1, in_ready4, out_valid1, out_valid4, ex_stall1, ex_stall4}, 6'b110000);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid4) seen = 1'b1;
        end
        check(tag, seen, 1'b0);
    endtask

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        op       = o;
        rs1_val  = a;
        rs2_val  = b;
        rd_in    = 6'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  o;
        logic [63:0] a, b;
        logic        word;

        #12;
        check("reset1", {in_ready1, out_valid1, ex_stall1, result1, rd_out1}, {3'b100, 64'd0, 6'd0});
        check("reset4", {in_ready4, out_valid4, ex_stall4, result4, rd_out4}, {3'b100, 64'd0, 6'd0});
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x-3",   OP_MUL,   64'd7, -64'sd3, 6'd1, 0);
        run_op("mulhu_ones", OP_MULHU, '1, '1, 6'd2, 0);
        run_op("div_-7/2",   OP_DIV,   -64'sd7, 64'd2, 6'd3, 0);
        run_op("rem_-7/2",   OP_REM,   -64'sd7, 64'd2, 6'd4, 0);
        run_op("divw_ovf",   OP_DIVW,  64'h0000_0000_8000_0000, '1, 6'd5, 0);
        run_op("divu_0",     OP_DIVU,  64'h1234_5678_9ABC_DEF0, 64'd0, 6'd6, 0);
        run_op("remu_0",     OP_REMU,  64'd5, 64'd0, 6'd7, 0);
        run_op("mulw_hold",  OP_MULW,  64'hDEAD_0000_FFFF_FFF0, 64'h0000_0003_0000_0011, 6'd8, 5);

        for (int i = 0; i < 40; i++) begin
            o    = 4'($urandom_range(0, 12));
            word = (o >= OP_MULW);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = word ? {$urandom, 32'h0} : 64'd0;
                1: begin
                    a = word ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = word ? {$urandom, 32'hFFFF_FFFF} : '1;
                end
                2: begin
                    a = 64'($urandom_range(0, 1000));
                    b = 64'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, 6'($urandom_range(0, 63)), 0);
        end

        // flush together with a request in IDLE: nothing is accepted
        op = OP_DIVU; rs2_val = '0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle", {in_ready1, in_ready4, out_valid1, out_valid4, ex_stall1, ex_stall4}, 6'b110000);

        // flush during DIV iterations
        issue(OP_DIV, 64'd1000, 64'd7);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_div", {in_ready1, in_ready4, out_valid1, out_valid4, ex_stall1, ex_stall4}, 6'b110000);
        watch_quiet("flush_div quiet", 80);

        // flush beats out_ready in DONE
        issue(OP_DIVU, 64'd3, 64'd0);
        check("special_done", {out_valid1, out_valid4}, 2'b11);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done", {in_ready1, in_ready4, out_valid1, out_valid4}, 4'b1100);

        // reset mid-MUL clears everything at once
        issue(OP_MULH, 64'h7777_0000_1234_5678, 64'h0000_0001_0000_0001);
        repeat (20) begin @(posedge clk); #1; end
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid1", {in_ready1, out_valid1, ex_stall1, result1, rd_out1}, {3'b100, 64'd0, 6'd0});
        check("rst_mid4", {in_ready4, out_valid4, ex_stall4, result4, rd_out4}, {3'b100, 64'd0, 6'd0});
        @(posedge clk); #1;
        reset = 1'b1;
        watch_quiet("rst_mid quiet", 80);

        run_op("after_rst", OP_MULHSU, -64'sd5, 64'hFFFF_FFFF_FFFF_FFFF, 6'd33, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
